// File: rtl/complex_power_acc.sv
// Per-sample complex power |x|^2 = re^2 + im^2 plus frame integration over a
// run-time programmable number of samples (acc_len, 0 meaning 2**ACC_LEN_BITS).
module complex_power_acc #(
    parameter int DIN_WIDTH    = 16,
    parameter int ACC_LEN_BITS = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [DIN_WIDTH-1:0]         din_re,
    input  logic signed [DIN_WIDTH-1:0]         din_im,
    input  logic                                din_valid,
    input  logic [ACC_LEN_BITS-1:0]             acc_len,
    input  logic                                acc_clear,
    output logic [2*DIN_WIDTH-1:0]              pow,
    output logic                                pow_valid,
    output logic [2*DIN_WIDTH+ACC_LEN_BITS-1:0] dout,
    output logic                                dout_valid
);

    // state | meaning
    // IDLE  | waiting for the first sample of a frame; acc_len is latched on it
    // RUN   | inside a frame; rem_r counts the samples still to come

    localparam int POW_WIDTH  = 2*DIN_WIDTH;
    localparam int DOUT_WIDTH = 2*DIN_WIDTH + ACC_LEN_BITS;
    localparam int LEN_WIDTH  = ACC_LEN_BITS + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [LEN_WIDTH-1:0]   rem_r, rem_nxt;
    logic [LEN_WIDTH-1:0]   len_in;
    logic                   first_nxt, last_nxt;

    logic                          s1_valid, s1_first, s1_last;
    logic signed [DIN_WIDTH-1:0]   s1_re, s1_im;
    logic                          s2_valid, s2_first, s2_last;
    logic [POW_WIDTH-1:0]          s2_re2, s2_im2;
    logic signed [POW_WIDTH-1:0]   re_sq, im_sq;
    logic                          s3_first, s3_last;
    logic [DOUT_WIDTH-1:0]         acc, acc_nxt;

    // Frame tracking runs on the input side so FIRST/LAST can ride along with the sample.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem_r;
        first_nxt = 1'b0;
        last_nxt  = 1'b0;
        len_in    = {1'b0, acc_len};
        if (acc_len == '0) begin
            len_in = {1'b1, {ACC_LEN_BITS{1'b0}}};
        end

        if (acc_clear) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
        end

        if (din_valid) begin
            if (acc_clear || state == IDLE) begin
                first_nxt = 1'b1;
                rem_nxt   = len_in - LEN_WIDTH'(1);
                if (len_in == LEN_WIDTH'(1)) begin
                    last_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RUN;
                end
            end else begin
                rem_nxt = rem_r - LEN_WIDTH'(1);
                if (rem_r == LEN_WIDTH'(1)) begin
                    last_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem_r <= '0;
        end else begin
            state <= state_nxt;
            rem_r <= rem_nxt;
        end
    end

    // S1: input capture
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= din_valid;
            s1_first <= din_valid & first_nxt;
            s1_last  <= din_valid & last_nxt;
        end
        s1_re <= din_re;
        s1_im <= din_im;
    end

    // Squares of a signed value are never negative, so the low POW_WIDTH bits are exact.
    always_comb begin
        re_sq = POW_WIDTH'(s1_re) * POW_WIDTH'(s1_re);
        im_sq = POW_WIDTH'(s1_im) * POW_WIDTH'(s1_im);
    end

    // S2: squares
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
        end
        s2_re2 <= $unsigned(re_sq);
        s2_im2 <= $unsigned(im_sq);
    end

    // S3: per-sample power, held between valid samples
    always_ff @(posedge clk) begin
        if (rst) begin
            pow       <= '0;
            pow_valid <= 1'b0;
            s3_first  <= 1'b0;
            s3_last   <= 1'b0;
        end else begin
            pow_valid <= s2_valid;
            s3_first  <= s2_first;
            s3_last   <= s2_last;
            if (s2_valid) begin
                pow <= s2_re2 + s2_im2;
            end
        end
    end

    always_comb begin
        if (s3_first) begin
            acc_nxt = DOUT_WIDTH'(pow);
        end else begin
            acc_nxt = acc + DOUT_WIDTH'(pow);
        end
    end

    // S4: frame accumulation; a FIRST sample overwrites whatever an aborted frame left.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= pow_valid & s3_last;
            if (pow_valid) begin
                acc <= acc_nxt;
                if (s3_last) begin
                    dout <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_power_acc.sv
// Bench for complex_power_acc: directed frame scenarios plus random traffic,
// checked cycle by cycle against a frame-level reference model.
module tb_complex_power_acc;

    localparam int DW = 16;
    localparam int LB = 3;
    localparam int PW = 2*DW;
    localparam int OW = 2*DW + LB;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] din_re = '0;
    logic signed [DW-1:0] din_im = '0;
    logic                 din_valid = 1'b0;
    logic [LB-1:0]        acc_len = '0;
    logic                 acc_clear = 1'b0;
    logic [PW-1:0]        pow;
    logic                 pow_valid;
    logic [OW-1:0]        dout;
    logic                 dout_valid;

    complex_power_acc #(.DIN_WIDTH(DW), .ACC_LEN_BITS(LB)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_re     (din_re),
        .din_im     (din_im),
        .din_valid  (din_valid),
        .acc_len    (acc_len),
        .acc_clear  (acc_clear),
        .pow        (pow),
        .pow_valid  (pow_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     due;
    } ev_t;

    ev_t    pow_q[$];
    ev_t    dout_q[$];
    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    longint exp_pow = 0;
    longint exp_dout = 0;
    int     rst_at = -1;
    int     fr_cnt = 0;
    int     fr_len = 0;
    longint fr_sum = 0;
    int     n_pulses = 0;
    longint last_obs_dout = 0;
    bit     ep, ed;
    int     base;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs compared every cycle, half a period after the edge.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (cyc == rst_at) begin
                exp_pow  = 0;
                exp_dout = 0;
            end
            ep = (pow_q.size() > 0) && (pow_q[0].due == cyc);
            if (ep) begin
                exp_pow = pow_q[0].val;
                void'(pow_q.pop_front());
            end
            ed = (dout_q.size() > 0) && (dout_q[0].due == cyc);
            if (ed) begin
                exp_dout = dout_q[0].val;
                void'(dout_q.pop_front());
            end
            check_val("pow_valid", 64'(pow_valid), 64'(ep));
            check_val("pow", 64'(pow), exp_pow);
            check_val("dout_valid", 64'(dout_valid), 64'(ed));
            check_val("dout", 64'(dout), exp_dout);
            if (dout_valid === 1'b1) begin
                n_pulses++;
                last_obs_dout = longint'(dout);
            end
        end
    end

    // Drive one cycle of input and feed the frame model with the same sample.
    task automatic drive(input bit v, input int re, input int im, input int len, input bit clr);
        longint p;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        din_valid = v;
        din_re    = re[DW-1:0];
        din_im    = im[DW-1:0];
        acc_len   = len[LB-1:0];
        acc_clear = clr;
        if (clr) fr_cnt = 0;
        if (v) begin
            p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
            pow_q.push_back('{p, cyc + 3});
            if (fr_cnt == 0) begin
                fr_len = (len == 0) ? (1 << LB) : len;
                fr_sum = 0;
            end
            fr_sum += p;
            fr_cnt++;
            if (fr_cnt == fr_len) begin
                dout_q.push_back('{fr_sum, cyc + 4});
                fr_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, int'(acc_len), 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rst == 1'b0) rst_at = cyc + 1;
            rst       = 1'b1;
            din_valid = 1'b0;
            acc_clear = 1'b0;
            fr_cnt    = 0;
        end
    endtask

    initial begin
        int re, im, len;
        bit v, clr;

        repeat (3) @(posedge clk);
        idle(4);
        check_val("t1_no_pulse", 64'(n_pulses), 64'd0);

        base = n_pulses;
        drive(1'b1, 3, -4, 1, 1'b0);
        idle(6);
        check_val("t2_pulses", 64'(n_pulses - base), 64'd1);
        check_val("t2_dout", 64'(last_obs_dout), 64'd25);

        base = n_pulses;
        repeat (4) drive(1'b1, -32768, -32768, 4, 1'b0);
        idle(6);
        check_val("t3_pulses", 64'(n_pulses - base), 64'd1);
        check_val("t3_dout", 64'(last_obs_dout), 64'd8589934592);

        base = n_pulses;
        drive(1'b1, 1, 0, 3, 1'b0);
        idle(2);
        drive(1'b1, 0, 2, 3, 1'b0);
        idle(2);
        drive(1'b1, 2, 2, 5, 1'b0);
        idle(6);
        check_val("t4_pulses", 64'(n_pulses - base), 64'd1);
        check_val("t4_dout", 64'(last_obs_dout), 64'd13);
        base = n_pulses;
        repeat (4) drive(1'b1, 1, 0, 5, 1'b0);
        idle(6);
        check_val("t4_len5_open", 64'(n_pulses - base), 64'd0);
        drive(1'b1, 1, 0, 5, 1'b0);
        idle(6);
        check_val("t4_len5_pulses", 64'(n_pulses - base), 64'd1);
        check_val("t4_len5_dout", 64'(last_obs_dout), 64'd5);

        base = n_pulses;
        repeat (2) drive(1'b1, 10, 0, 4, 1'b0);
        drive(1'b1, 1, 1, 4, 1'b1);
        repeat (3) drive(1'b1, 1, 1, 4, 1'b0);
        idle(6);
        check_val("t5_pulses", 64'(n_pulses - base), 64'd1);
        check_val("t5_dout", 64'(last_obs_dout), 64'd8);

        base = n_pulses;
        repeat (8) drive(1'b1, 1, 1, 0, 1'b0);
        idle(6);
        check_val("t6_pulses", 64'(n_pulses - base), 64'd1);
        check_val("t6_dout", 64'(last_obs_dout), 64'd16);
        base = n_pulses;
        repeat (3) drive(1'b1, 5, 5, 0, 1'b0);
        idle(6);
        do_reset(2);
        drive(1'b1, 2, 0, 2, 1'b0);
        drive(1'b1, 0, 3, 2, 1'b0);
        idle(6);
        check_val("t6_rst_pulses", 64'(n_pulses - base), 64'd1);
        check_val("t6_rst_dout", 64'(last_obs_dout), 64'd13);

        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 19) == 0);
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) begin
                re = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
                im = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
            end else begin
                re = int'($urandom_range(0, 65535)) - 32768;
                im = int'($urandom_range(0, 65535)) - 32768;
            end
            drive(v, re, im, len, clr);
        end
        idle(8);
        check_val("queues_drained", 64'(pow_q.size() + dout_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
